// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with frame debounce.
// Optional auto-repeat of a held key when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner #(
   parameter int SCAN_DIV_W      = 16,
   parameter int DEBOUNCE_FRAMES = 4,
   parameter int REPEAT_FRAMES   = 32
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_key_code,
   output logic       o_key_valid,
   input  logic       i_key_ack,
   output logic       o_key_down,
   output logic       o_overrun
);

   localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [CW-1:0] DF_C = CW'(DEBOUNCE_FRAMES);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

   logic [3:0]            sync1_q, sync1_d, sync2_q, sync2_d;
   logic [SCAN_DIV_W-1:0] pre_q, pre_d;
   logic [1:0]            col_q, col_d;
   logic [3:0]            ocol_q, ocol_d;
   logic                  acc_hit_q, acc_hit_d;
   logic [3:0]            acc_code_q, acc_code_d;
   state_t                state_q, state_d;
   logic [3:0]            cand_q, cand_d;
   logic [CW-1:0]         dcnt_q, dcnt_d, rcnt_q, rcnt_d;
   logic [3:0]            code_q, code_d;
   logic                  valid_q, valid_d;
   logic                  down_q, down_d;
   logic                  ovr_q, ovr_d;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_FRAMES + 1);
   localparam logic [RW-1:0] RF_C = RW'(REPEAT_FRAMES);
   logic [RW-1:0]         rpt_q, rpt_d;
`endif

   logic       tick, frame_end, samp_hit, frame_hit, emit;
   logic [1:0] samp_row;
   logic [3:0] samp_code, frame_code;

   // Lowest low row in the current column wins.
   always_comb begin
      samp_row = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!sync2_q[r]) samp_row = r[1:0];
      end
   end

   assign tick       = &pre_q;
   assign frame_end  = tick && (col_q == 2'd3);
   assign samp_hit   = ~&sync2_q;
   assign samp_code  = {samp_row, col_q};
   assign frame_hit  = acc_hit_q | samp_hit;
   assign frame_code = acc_hit_q ? acc_code_q : samp_code;

   // Synchronizer, prescaler, column rotation and per-frame accumulation.
   always_comb begin
      sync1_d    = i_row;
      sync2_d    = sync1_q;
      pre_d      = pre_q + 1'b1;
      col_d      = col_q;
      acc_hit_d  = acc_hit_q;
      acc_code_d = acc_code_q;
      if (tick) begin
         col_d = col_q + 2'd1;
         if (col_q == 2'd3) begin
            acc_hit_d  = 1'b0;
            acc_code_d = 4'd0;
         end else if (!acc_hit_q && samp_hit) begin
            acc_hit_d  = 1'b1;
            acc_code_d = samp_code;
         end
      end
      ocol_d = ~(4'b0001 << col_d);
   end

   // Scan datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync1_q    <= 4'b1111;
         sync2_q    <= 4'b1111;
         pre_q      <= '0;
         col_q      <= 2'd0;
         ocol_q     <= 4'b1110;
         acc_hit_q  <= 1'b0;
         acc_code_q <= 4'd0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         pre_q      <= pre_d;
         col_q      <= col_d;
         ocol_q     <= ocol_d;
         acc_hit_q  <= acc_hit_d;
         acc_code_q <= acc_code_d;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         cand_q  <= 4'd0;
         dcnt_q  <= '0;
         rcnt_q  <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         dcnt_q  <= dcnt_d;
         rcnt_q  <= rcnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   // FSM next state; emit pulses on the frame end that accepts a key.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      dcnt_d  = dcnt_q;
      rcnt_d  = rcnt_q;
      emit    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_d   = rpt_q;
`endif
      if (frame_end) begin
         unique case (state_q)
            IDLE: begin
               if (frame_hit) begin
                  cand_d = frame_code;
                  dcnt_d = CW'(1);
                  rcnt_d = '0;
                  if (DEBOUNCE_FRAMES == 1) begin
                     emit    = 1'b1;
                     state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rpt_d   = '0;
`endif
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (frame_hit && (frame_code == cand_q)) begin
                  dcnt_d = dcnt_q + CW'(1);
                  if (dcnt_d == DF_C) begin
                     emit    = 1'b1;
                     state_d = PRESSED;
                     rcnt_d  = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     rpt_d   = '0;
`endif
                  end
               end else begin
                  state_d = IDLE;
                  dcnt_d  = '0;
               end
            end
            PRESSED: begin
               if (frame_hit) begin
                  rcnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (rpt_q + RW'(1) == RF_C) begin
                     rpt_d = '0;
                     emit  = 1'b1;
                  end else begin
                     rpt_d = rpt_q + RW'(1);
                  end
`endif
               end else begin
                  rcnt_d = rcnt_q + CW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
                  rpt_d  = '0;
`endif
                  if (rcnt_d == DF_C) begin
                     state_d = IDLE;
                     dcnt_d  = '0;
                     rcnt_d  = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output handshake: load on emit when free or acked, else flag overrun.
   always_comb begin
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      down_d  = (state_d == PRESSED);
      if (emit) begin
         if (!valid_q || i_key_ack) begin
            code_d  = cand_d;
            valid_d = 1'b1;
            if (valid_q) ovr_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && i_key_ack) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         code_q  <= 4'd0;
         valid_q <= 1'b0;
         down_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         code_q  <= code_d;
         valid_q <= valid_d;
         down_q  <= down_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_col       = ocol_q;
   assign o_key_code  = code_q;
   assign o_key_valid = valid_q;
   assign o_key_down  = down_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench with a behavioural key matrix.
// Frame = 16 clocks; bench stays aligned to frame boundaries.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  code;
   logic        valid;
   logic        down;
   logic        ovr;
   logic [15:0] keys = 16'h0;
   int          errs = 0;
   int          checks = 0;
   int          n;
   logic [3:0]  e_col;

   always #5 clk = ~clk;

   // Pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   keypad_scanner #(
      .SCAN_DIV_W(2),
      .DEBOUNCE_FRAMES(3),
      .REPEAT_FRAMES(4)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_row(row),
      .o_col(col),
      .o_key_code(code),
      .o_key_valid(valid),
      .i_key_ack(ack),
      .o_key_down(down),
      .o_overrun(ovr)
   );

   task automatic chk(input string tag, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic frames(input int k);
      cyc(16 * k);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      cyc(2);
      rst = 1'b0;
      cyc(6);
      chk("col_prerst", 8'(col), 8'hD);
      #2 rst = 1'b1;
      #1;
      chk("rst_col", 8'(col), 8'hE);
      chk("rst_valid", 8'(valid), 8'h0);
      chk("rst_ovr", 8'(ovr), 8'h0);
      chk("rst_down", 8'(down), 8'h0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 16; k++) begin
         e_col = ~(4'b0001 << (k / 4));
         chk("rotate", 8'(col), 8'(e_col));
         cyc(1);
      end

      // clean press of key 9
      keys[9] = 1'b1;
      frames(2);
      chk("p9_f2_valid", 8'(valid), 8'h0);
      cyc(15);
      chk("p9_pre_valid", 8'(valid), 8'h0);
      cyc(1);
      chk("p9_valid", 8'(valid), 8'h1);
      chk("p9_code", 8'(code), 8'h9);
      chk("p9_down", 8'(down), 8'h1);
      chk("p9_ovr", 8'(ovr), 8'h0);
      frames(2);
      chk("p9_hold", 8'(valid), 8'h1);
      keys = 16'h0;
      ack_pulse();
      chk("p9_ack", 8'(valid), 8'h0);
      cyc(15);
      frames(1);
      chk("p9_rel2", 8'(down), 8'h1);
      frames(1);
      chk("p9_rel3", 8'(down), 8'h0);

      // bounce: 2 on, 1 off, 2 on
      keys[9] = 1'b1;
      frames(2);
      keys = 16'h0;
      frames(1);
      keys[9] = 1'b1;
      frames(2);
      chk("bnc_down", 8'(down), 8'h0);
      keys = 16'h0;
      frames(3);
      chk("bnc_valid", 8'(valid), 8'h0);

      // overrun: 9 pending, then 4 dropped
      keys[9] = 1'b1;
      frames(3);
      chk("ov_valid9", 8'(valid), 8'h1);
      keys = 16'h0;
      frames(3);
      chk("ov_rel", 8'(down), 8'h0);
      keys[4] = 1'b1;
      frames(3);
      chk("ov_code", 8'(code), 8'h9);
      chk("ov_valid", 8'(valid), 8'h1);
      chk("ov_flag", 8'(ovr), 8'h1);
      chk("ov_down", 8'(down), 8'h1);
      keys = 16'h0;
      ack_pulse();
      chk("ov_ack_valid", 8'(valid), 8'h0);
      chk("ov_ack_ovr", 8'(ovr), 8'h0);
      cyc(15);
      frames(3);
      chk("ov_rel4", 8'(down), 8'h0);

      // ack on the emit cycle of key 4 while 9 pending
      keys[9] = 1'b1;
      frames(3);
      chk("co_code9", 8'(code), 8'h9);
      keys = 16'h0;
      frames(3);
      keys[4] = 1'b1;
      frames(2);
      cyc(15);
      ack = 1'b1;
      cyc(1);
      ack = 1'b0;
      chk("co_code", 8'(code), 8'h4);
      chk("co_valid", 8'(valid), 8'h1);
      chk("co_ovr", 8'(ovr), 8'h0);
      keys = 16'h0;
      ack_pulse();
      chk("co_ack", 8'(valid), 8'h0);
      ack_pulse();
      chk("idle_ack_v", 8'(valid), 8'h0);
      chk("idle_ack_o", 8'(ovr), 8'h0);
      cyc(14);
      frames(3);

      // two keys in column 2: rows 0 and 3 -> code 2
      keys[2]  = 1'b1;
      keys[14] = 1'b1;
      n = 0;
      for (int f = 0; f < 20; f++) begin
         for (int c = 0; c < 16; c++) begin
            if (valid) begin
               n++;
               chk("two_code", 8'(code), 8'h2);
               ack = 1'b1;
            end else begin
               ack = 1'b0;
            end
            @(negedge clk);
         end
      end
      ack = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("two_emits", 8'(n), 8'd5);
`else
      chk("two_emits", 8'(n), 8'd1);
`endif
      chk("two_down", 8'(down), 8'h1);
      keys = 16'h0;
      frames(3);
      chk("two_rel", 8'(down), 8'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
